// File: rtl/axi_master.sv
// Single-outstanding AXI4 master: one command in, one single-beat AXI transaction out.
// Optional handshake timeout abort enabled with `define AXI_MASTER_TIMEOUT_EN.
module axi_master #(
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [31:0] awaddr,
  output logic [7:0]  awlen,
  output logic        awvalid,
  input  logic        awready,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wvalid,
  input  logic        wready,
  input  logic        bvalid,
  output logic        bready,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic        arvalid,
  input  logic        arready,
  input  logic [31:0] rdata,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [2:0] {IDLE, WRITE, WRESP, READ, RDATA, DONE} state_t;

  state_t      state, state_n;
  logic        aw_done, w_done;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [3:0]  wstrb_q;
  logic        timeout_hit;
  logic        abort;

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("axi_master: TIMEOUT_CYCLES must be at least 2");
  end

  always_comb begin
    state_n = state;
    abort   = 1'b0;
    case (state)
      IDLE:  if (cmd_valid) state_n = cmd_write ? WRITE : READ;
      // AW and W complete independently; done flags remember an earlier handshake
      WRITE: begin
        if ((aw_done || awready) && (w_done || wready)) state_n = WRESP;
        else if (timeout_hit) begin state_n = DONE; abort = 1'b1; end
      end
      WRESP: begin
        if (bvalid) state_n = DONE;
        else if (timeout_hit) begin state_n = DONE; abort = 1'b1; end
      end
      READ: begin
        if (rvalid) state_n = DONE;
        else if (arready) state_n = RDATA;
        else if (timeout_hit) begin state_n = DONE; abort = 1'b1; end
      end
      RDATA: begin
        if (rvalid) state_n = DONE;
        else if (timeout_hit) begin state_n = DONE; abort = 1'b1; end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      rdata_q <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && cmd_valid) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (state == WRITE) begin
        if (awready) aw_done <= 1'b1;
        if (wready)  w_done  <= 1'b1;
      end
      if ((state == READ || state == RDATA) && rvalid) rdata_q <= rdata;
      else if (abort) rdata_q <= '0;
    end
  end

`ifdef AXI_MASTER_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      err_q <= 1'b0;
    end else begin
      cnt   <= (state_n != state || state == IDLE) ? '0 : cnt + 1'b1;
      err_q <= (state_n == DONE) ? abort : 1'b0;
    end
  end

  // cnt counts completed cycles in the state, so this fires on the TIMEOUT_CYCLES-th cycle
  assign timeout_hit = (cnt == CW'(TIMEOUT_CYCLES - 1));
  assign rsp_err     = err_q;
`else
  assign timeout_hit = 1'b0;
  assign rsp_err     = 1'b0;
`endif

  assign cmd_ready = (state == IDLE);
  assign rsp_valid = (state == DONE);
  assign rsp_rdata = rdata_q;
  assign awaddr    = addr_q;
  assign araddr    = addr_q;
  assign awlen     = '0;
  assign arlen     = '0;
  assign wdata     = wdata_q;
  assign wstrb     = wstrb_q;
  assign awvalid   = (state == WRITE) && !aw_done;
  assign wvalid    = (state == WRITE) && !w_done;
  assign bready    = (state == WRESP);
  assign arvalid   = (state == READ);
  assign rready    = (state == READ) || (state == RDATA);

endmodule

// File: tb/tb_axi_master.sv
// Scoreboard bench for axi_master against a behavioural AXI slave with programmable delays.
module tb_axi_master;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [7:0]  awlen, arlen;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;

  axi_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awaddr(awaddr), .awlen(awlen), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arlen(arlen), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rvalid(rvalid), .rready(rready)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  typedef struct {
    bit          is_read;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  exp_t sb[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- slave model ----------------
  int unsigned aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  bit          ar_block = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;

  initial begin
    int unsigned aw_cnt = 0, w_cnt = 0, b_cnt = 0, ar_cnt = 0, r_cnt = 0;
    logic [31:0] old;
    awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; rdata = '0;
    forever begin
      @(posedge clk); #1;
      if (reset) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
      end else begin
        if (awvalid) begin
          if (aw_cnt >= aw_delay) awready = 1; else aw_cnt++;
        end else begin awready = 0; aw_cnt = 0; end
        if (wvalid) begin
          if (w_cnt >= w_delay) begin
            wready = 1; wr_addr = awaddr; wr_data = wdata; wr_strb = wstrb;
          end else w_cnt++;
        end else begin wready = 0; w_cnt = 0; end
        if (bready) begin
          if (b_cnt >= b_delay) begin
            if (!bvalid) begin
              old = mem.exists(wr_addr) ? mem[wr_addr] : '0;
              for (int i = 0; i < 4; i++)
                if (wr_strb[i]) old[i*8 +: 8] = wr_data[i*8 +: 8];
              mem[wr_addr] = old;
            end
            bvalid = 1;
          end else b_cnt++;
        end else begin bvalid = 0; b_cnt = 0; end
        if (arvalid && !ar_block) begin
          if (ar_cnt >= ar_delay) arready = 1; else ar_cnt++;
        end else begin arready = 0; ar_cnt = 0; end
        if (rready) begin
          if (r_cnt >= r_delay) begin
            rvalid = 1; rdata = mem.exists(araddr) ? mem[araddr] : '0;
          end else r_cnt++;
        end else begin rvalid = 0; r_cnt = 0; end
      end
    end
  end

  // ---------------- monitor ----------------
  logic [31:0] exp_addr = '0, exp_wdata = '0;
  logic [3:0]  exp_wstrb = '0;
  bit          prev_rsp = 0, prev_bready = 0, seen_wdrop = 0;
  int unsigned bresp_count = 0, rsp_count = 0, rsp_expected = 0;

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      prev_rsp = 0; prev_bready = 0;
    end else begin
      if (rsp_valid) begin
        rsp_count++;
        check("rsp_single_pulse", prev_rsp, 0);
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL rsp_unexpected: got rsp_valid=1 expected no response");
        end else begin
          e = sb.pop_front();
          check("rsp_err", rsp_err, e.err);
          if (e.is_read) check("rsp_rdata", rsp_rdata, e.rdata);
        end
      end
      if (awvalid || wvalid || bready) begin
        check("awaddr_hold", awaddr, exp_addr);
        check("wdata_hold", wdata, exp_wdata);
        check("wstrb_hold", wstrb, exp_wstrb);
      end
      if (awvalid || wvalid || bready || arvalid || rready || rsp_valid)
        check("cmd_ready_busy", cmd_ready, 0);
      if (awvalid && !wvalid) seen_wdrop = 1;
      if (bready && !prev_bready) bresp_count++;
      prev_rsp    = rsp_valid;
      prev_bready = bready;
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input bit exp_rsp, input logic [31:0] exp_rd,
                       input bit exp_err, output int unsigned acc_cyc);
    bit ok, acc;
    exp_t e;
    cmd_write = wr; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1;
    if (wr) begin exp_addr = a; exp_wdata = d; exp_wstrb = s; end
    if (exp_rsp) begin
      e.is_read = !wr; e.rdata = exp_rd; e.err = exp_err;
      sb.push_back(e);
      rsp_expected++;
    end
    acc = 0; acc_cyc = 0;
    for (int i = 0; i < 100 && !acc; i++) begin
      ok = cmd_ready; acc_cyc = cyc;
      @(posedge clk); #1;
      if (ok) acc = 1;
    end
    cmd_valid = 0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL cmd_accept: got no accept expected cmd_ready within 100 cycles");
    end
  endtask

  task automatic wait_rsp(output int unsigned c);
    bit got = 0;
    c = 0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(posedge clk); #1;
      if (rsp_valid) begin got = 1; c = cyc; end
    end
    if (!got) begin
      checks++; errors++;
      $display("FAIL rsp_wait: got no rsp_valid expected one within 200 cycles");
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_awvalid"}, awvalid, 0);
    check({tag, "_wvalid"}, wvalid, 0);
    check({tag, "_bready"}, bready, 0);
    check({tag, "_arvalid"}, arvalid, 0);
    check({tag, "_rready"}, rready, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_err"}, rsp_err, 0);
    check({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
  endtask

  initial begin
    int unsigned c0, c1;
    bit got;
    reset = 1; cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    reset = 0;
    @(posedge clk); #1;
    check("post_reset_cmd_ready", cmd_ready, 1);
    check("awlen_zero", awlen, 8'h0);
    check("arlen_zero", arlen, 8'h0);

    // write 0x10 with slave answering each channel after one cycle
    aw_delay = 1; w_delay = 1; b_delay = 1;
    issue(1, 32'h10, 32'hDEADBEEF, 4'hF, 1, '0, 0, c0);
    wait_rsp(c1);

    // read back
    ar_delay = 1; r_delay = 2;
    issue(0, 32'h10, '0, 4'h0, 1, 32'hDEADBEEF, 0, c0);
    wait_rsp(c1);

    // zero-wait write: minimum latency
    aw_delay = 0; w_delay = 0; b_delay = 0; ar_delay = 0; r_delay = 0;
    issue(1, 32'h14, 32'h11223344, 4'hF, 1, '0, 0, c0);
    wait_rsp(c1);
    check("write_latency", c1 - c0, 3);

    // partial strobe merge, read with rvalid alongside arready
    issue(1, 32'h14, 32'hAABBCCDD, 4'h5, 1, '0, 0, c0);
    wait_rsp(c1);
    issue(0, 32'h14, '0, 4'h0, 1, 32'h11BB33DD, 0, c0);
    wait_rsp(c1);

    // awready late, wready immediate
    seen_wdrop = 0; bresp_count = 0;
    aw_delay = 4; w_delay = 0; b_delay = 0;
    issue(1, 32'h18, 32'hCAFEF00D, 4'hF, 1, '0, 0, c0);
    wait_rsp(c1);
    check("wvalid_drops_first", seen_wdrop, 1);
    check("single_wresp", bresp_count, 1);
    aw_delay = 0; r_delay = 1;
    issue(0, 32'h18, '0, 4'h0, 1, 32'hCAFEF00D, 0, c0);
    wait_rsp(c1);

    // reset during WRESP abandons the write
    b_delay = 20;
    issue(1, 32'h10, 32'h12345678, 4'hF, 0, '0, 0, c0);
    got = 0;
    for (int i = 0; i < 50 && !got; i++) begin
      if (bready) got = 1; else begin @(posedge clk); #1; end
    end
    check("reached_wresp", got, 1);
    reset = 1;
    @(posedge clk); #1;
    check_reset_outputs("mid_reset");
    reset = 0;
    @(posedge clk); #1;
    check("mid_reset_cmd_ready", cmd_ready, 1);
    b_delay = 0; r_delay = 0;
    issue(0, 32'h10, '0, 4'h0, 1, 32'hDEADBEEF, 0, c0);
    wait_rsp(c1);

    // rvalid ahead of arready
    ar_delay = 3; r_delay = 0;
    issue(0, 32'h14, '0, 4'h0, 1, 32'h11BB33DD, 0, c0);
    wait_rsp(c1);
    check("early_r_arvalid_off", arvalid, 0);
    ar_delay = 0;

`ifdef AXI_MASTER_TIMEOUT_EN
    ar_block = 1; r_delay = 1000;
    issue(0, 32'h10, '0, 4'h0, 1, 32'h0, 1, c0);
    wait_rsp(c1);
    check("timeout_latency", c1 - c0, 1 + TO);
    check("timeout_arvalid", arvalid, 0);
    check("timeout_rready", rready, 0);
    ar_block = 0; r_delay = 0;
`endif

    repeat (3) @(posedge clk);
    #1;
    check("rsp_count", rsp_count, rsp_expected);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got still running expected finish");
    $fatal(1, "simulation time limit");
  end

endmodule
